// File: rtl/mem_lsu_align.sv
// mem_lsu_align
//   Load/store front end for a 32-word x 32-bit byte-enabled simple-dual-port
//   data RAM with a pipelined read path. It accepts one byte-addressed LB/LH/LW/
//   LBU/LHU/SB/SH/SW request at a time over a valid/ready handshake. It drives
//   the RAM write port (ada/din/byte_ena/cea) and the RAM read port
//   (adb/ceb/oce). It returns one aligned, extended response per request.
//   Misaligned accesses are answered with an error and never touch the RAM.
//
// Ports
//   clk, reset             single clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_we                 1 = store, 0 = load
//   req_size               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned           loads: 1 zero-extend, 0 sign-extend
//   req_addr, req_wdata    byte address, right-justified store data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     extended load data (0 otherwise), error flag
//   ram_ada/din/byte_ena/cea   RAM write port
//   ram_adb/ceb/oce            RAM read port, ram_dout read data
module mem_lsu_align #(
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] ram_ada,
    output logic [31:0]       ram_din,
    output logic [3:0]        ram_byte_ena,
    output logic              ram_cea,
    output logic [ADDR_W-3:0] ram_adb,
    output logic              ram_ceb,
    output logic              ram_oce,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_t;

    // The read counter starts at 0 on the ceb cycle. RAM data is valid once it reaches RD_LAT.
    localparam logic [1:0] RD_LAST = 2'(RD_LAT);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        rd_cnt;
    logic              accept;
    logic              misaligned;
    logic              rd_done;
    logic              rsp_fire;
    logic [31:0]       lane_shifted;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign rd_done   = (state == RD_WAIT) && (rd_cnt == RD_LAST);

    // Alignment is judged on the live request, so an error can be reported
    // one cycle after accept without ever touching the RAM.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Only one RAM operation is ever in flight, because the
    // FSM cannot leave RESP until the response has been consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_nxt = RESP;
                    end else if (req_we) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            WR:      state_nxt = RESP;
            RD_WAIT: if (rd_done) state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, read-latency counter and response registers.
    // The response holds still while it is stalled and clears once it is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_cnt     <= 2'b00;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rd_cnt     <= 2'b00;
                rsp_rdata  <= 32'h0;
                rsp_err    <= misaligned;
            end else if ((state == RD_WAIT) && !rd_done) begin
                rd_cnt <= rd_cnt + 2'd1;
            end

            if (rd_done) begin
                rsp_rdata <= ld_data;
                rsp_err   <= 1'b0;
            end else if (state == WR) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b0;
            end else if (rsp_fire) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Write port. Data is replicated across lanes so that byte_ena alone picks the target bytes.
    // Every field is zero outside the single WR cycle.
    always_comb begin
        ram_cea      = (state == WR);
        ram_ada      = '0;
        ram_din      = 32'h0;
        ram_byte_ena = 4'b0000;
        if (ram_cea) begin
            ram_ada = addr_q[ADDR_W-1:2];
            case (size_q)
                2'b00: begin
                    ram_byte_ena = 4'b0001 << addr_q[1:0];
                    ram_din      = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    ram_byte_ena = 4'b0011 << addr_q[1:0];
                    ram_din      = {2{wdata_q[15:0]}};
                end
                default: begin
                    ram_byte_ena = 4'b1111;
                    ram_din      = wdata_q;
                end
            endcase
        end
    end

    // Read port. ceb pulses on the first RD_WAIT cycle only. oce stays high for
    // the whole wait so the output register keeps advancing.
    always_comb begin
        ram_oce = (state == RD_WAIT);
        ram_ceb = ram_oce && (rd_cnt == 2'b00);
        ram_adb = '0;
        if (ram_oce) begin
            ram_adb = addr_q[ADDR_W-1:2];
        end
    end

    // Lane select and extension of the RAM word for the captured load.
    always_comb begin
        lane_shifted = ram_dout >> {addr_q[1:0], 3'b000};
        ld_byte      = lane_shifted[7:0];
        ld_half      = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
        ld_data      = ram_dout;
        case (size_q)
            2'b00:   ld_data = unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ram_dout;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu_align.sv
// tb_mem_lsu_align
//   Testbench for mem_lsu_align. It contains a small byte-enabled RAM with a two-stage read
//   pipeline (ceb stage, then the oce output register). A table of directed
//   transactions with hand-computed results is applied in order. After the table,
//   a back-pressure sequence and a reset-during-read sequence are run.
module tb_mem_lsu_align;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  ram_ada;
    logic [31:0] ram_din;
    logic [3:0]  ram_byte_ena;
    logic        ram_cea;
    logic [4:0]  ram_adb;
    logic        ram_ceb;
    logic        ram_oce;
    logic [31:0] ram_dout;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_lsu_align #(.ADDR_W(7), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_ada      (ram_ada),
        .ram_din      (ram_din),
        .ram_byte_ena (ram_byte_ena),
        .ram_cea      (ram_cea),
        .ram_adb      (ram_adb),
        .ram_ceb      (ram_ceb),
        .ram_oce      (ram_oce),
        .ram_dout     (ram_dout)
    );

    // RAM model. Data goes from ceb to a stage register, and then through oce to dout.
    logic [31:0] mem [32];
    logic [31:0] rd_stage;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_stage <= 32'h0;
            ram_dout <= 32'h0;
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else begin
            if (ram_cea) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byte_ena[b]) mem[ram_ada][8*b +: 8] <= ram_din[8*b +: 8];
            end
            if (ram_ceb) rd_stage <= mem[ram_adb];
            if (ram_oce) ram_dout <= rd_stage;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_bena;
        logic [31:0] exp_din;
        logic [4:0]  exp_word;
        int          exp_lat;
    } vec_t;

    vec_t vecs [17];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // This task runs one transaction and checks its handshake, its RAM strobes and its response.
    // The response is left stalled for 'hold' cycles before it is taken.
    task automatic apply_stimulus(input vec_t v, input int hold, input string tag);
        int          lat;
        int          n_cea;
        int          n_ceb;
        int          n_both;
        logic [3:0]  bena;
        logic [31:0] din;
        logic [4:0]  ada;
        logic [4:0]  adb;
        logic [31:0] got_rdata;
        logic        got_err;
        lat = 0; n_cea = 0; n_ceb = 0; n_both = 0;
        bena = '0; din = '0; ada = '0; adb = '0;
        got_rdata = '0; got_err = 1'b0;

        @(negedge clk);
        check_output({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0;

        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ram_cea) begin
                n_cea++;
                bena = ram_byte_ena;
                din  = ram_din;
                ada  = ram_ada;
            end
            if (ram_ceb) begin
                n_ceb++;
                adb = ram_adb;
            end
            if (ram_cea && ram_ceb) n_both++;
            if (rsp_valid) begin
                lat       = k;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                break;
            end
        end

        check_output({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check_output({tag, " rsp_err"}, 32'(got_err), 32'(v.exp_err));
        check_output({tag, " rsp_rdata"}, got_rdata, v.exp_rdata);
        check_output({tag, " cea pulses"}, 32'(n_cea), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        check_output({tag, " ceb pulses"}, 32'(n_ceb), (!v.we && !v.exp_err) ? 32'd1 : 32'd0);
        check_output({tag, " cea&ceb overlap"}, 32'(n_both), 32'd0);
        if (v.we && !v.exp_err) begin
            check_output({tag, " byte_ena"}, 32'(bena), 32'(v.exp_bena));
            check_output({tag, " din"}, din, v.exp_din);
            check_output({tag, " ada"}, 32'(ada), 32'(v.exp_word));
        end
        if (!v.we && !v.exp_err) begin
            check_output({tag, " adb"}, 32'(adb), 32'(v.exp_word));
        end

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_output({tag, " held rsp_valid"}, 32'(rsp_valid), 32'd1);
            check_output({tag, " held rsp_rdata"}, rsp_rdata, v.exp_rdata);
            check_output({tag, " held req_ready"}, 32'(req_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_output({tag, " rsp_valid after take"}, 32'(rsp_valid), 32'd0);
        check_output({tag, " req_ready after take"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int seen_valid;
        // {we, size, uns, addr, wdata, err, rdata, byte_ena, din, word, latency}
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, 1'b0, 32'h00000000, 4'b1111, 32'hDEADBEEF, 5'd2, 2};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 7'h08, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000, 32'h0,        5'd2, 4};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 7'h0D, 32'h00000080, 1'b0, 32'h00000000, 4'b0010, 32'h80808080, 5'd3, 2};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 7'h0D, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000, 32'h0,        5'd3, 4};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 7'h0D, 32'h0,        1'b0, 32'h00000080, 4'b0000, 32'h0,        5'd3, 4};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 7'h0C, 32'h0,        1'b0, 32'h00008000, 4'b0000, 32'h0,        5'd3, 4};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 7'h0C, 32'h0,        1'b0, 32'h00000000, 4'b0000, 32'h0,        5'd3, 4};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 7'h12, 32'h00008001, 1'b0, 32'h00000000, 4'b1100, 32'h80018001, 5'd4, 2};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 7'h12, 32'h0,        1'b0, 32'hFFFF8001, 4'b0000, 32'h0,        5'd4, 4};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 7'h12, 32'h0,        1'b0, 32'h00008001, 4'b0000, 32'h0,        5'd4, 4};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 7'h13, 32'h1234567F, 1'b0, 32'h00000000, 4'b1000, 32'h7F7F7F7F, 5'd4, 2};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 7'h10, 32'h0,        1'b0, 32'h7F010000, 4'b0000, 32'h0,        5'd4, 4};
        vecs[12] = '{1'b0, 2'b01, 1'b0, 7'h12, 32'h0,        1'b0, 32'h00007F01, 4'b0000, 32'h0,        5'd4, 4};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 7'h05, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0,        5'd0, 1};
        vecs[14] = '{1'b0, 2'b01, 1'b0, 7'h03, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0,        5'd0, 1};
        vecs[15] = '{1'b0, 2'b11, 1'b0, 7'h00, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0,        5'd0, 1};
        vecs[16] = '{1'b1, 2'b10, 1'b0, 7'h06, 32'h55555555, 1'b1, 32'h00000000, 4'b0000, 32'h0,        5'd0, 1};

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 7'h0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_output("reset req_ready", 32'(req_ready), 32'd1);
        check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset rsp_rdata", rsp_rdata, 32'h0);
        check_output("reset rsp_err", 32'(rsp_err), 32'd0);
        check_output("reset ram strobes", {29'h0, ram_cea, ram_ceb, ram_oce}, 32'h0);
        check_output("reset ram_byte_ena", 32'(ram_byte_ena), 32'h0);
        check_output("reset ram_din", ram_din, 32'h0);
        check_output("reset ram addrs", {22'h0, ram_ada, ram_adb}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i], 0, $sformatf("vec%0d", i));
        end

        $display("[TB] back-pressure on LW 0x08");
        apply_stimulus(vecs[1], 5, "stall");

        $display("[TB] reset asserted during RD_WAIT");
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 7'h08;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_output("midreset ceb issued", 32'(ram_ceb), 32'd1);
        @(negedge clk);
        check_output("midreset oce in wait", 32'(ram_oce), 32'd1);
        reset = 1'b1;
        #1;
        check_output("midreset req_ready", 32'(req_ready), 32'd1);
        check_output("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("midreset rsp_rdata", rsp_rdata, 32'h0);
        check_output("midreset rsp_err", 32'(rsp_err), 32'd0);
        check_output("midreset ram strobes", {29'h0, ram_cea, ram_ceb, ram_oce}, 32'h0);
        check_output("midreset ram_adb", 32'(ram_adb), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) seen_valid++;
        end
        check_output("midreset no response", 32'(seen_valid), 32'd0);

        // The reset cleared the RAM model, so store a word again and read it back.
        apply_stimulus(vecs[0], 0, "post-reset SW");
        apply_stimulus(vecs[1], 0, "post-reset LW");

        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got %0d/%0d checks", n_pass, n_total);
        $fatal(1, "[TB] timeout");
    end

endmodule
